// File: rtl/adau1361_receiver.sv
// I2S capture from the ADAU1361 ADC: synchronise BCLK/LRCLK/data, deserialise left/right words, hand pairs out on a valid/ready hold register.
// Optional half-frame length checking is enabled by defining ADAU1361_RX_FRAME_CHECK_EN.

module adau1361_rx_chan #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift,
  input  logic         dat,
`ifdef ADAU1361_RX_FRAME_CHECK_EN
  input  logic         close,
  output logic         len_err,
`endif
  output logic [W-1:0] word_nxt
);

  logic [W-1:0] sh;

  // word_nxt already contains the bit being shifted in, so a closing bit is seen in the latched word
  assign word_nxt = {sh[W-2:0], dat};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sh <= '0;
    else if (shift) sh <= word_nxt;
  end

`ifdef ADAU1361_RX_FRAME_CHECK_EN
  logic [5:0] cnt;
  logic [5:0] cnt_inc;

  assign cnt_inc = (cnt == 6'd63) ? cnt : cnt + 6'd1;
  assign len_err = close && (cnt_inc != 6'(W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (shift) cnt <= close ? 6'd0 : cnt_inc;
  end
`endif

endmodule

module adau1361_receiver #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_bclk,
  input  logic                  i_lrclk,
  input  logic                  i_afAdcData,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_leftData,
  output logic [DATA_WIDTH-1:0] o_rightData,
  output logic                  o_overrun,
  output logic                  o_frameError
);

  localparam int STAGES = 1;

  logic [2:0]                       sync1, sync2;
  logic                             bclk_d;
  logic                             bclk_rise, lr_now, dat_now;
  logic                             lr_init, lr_valid, lr_prev;
  logic                             cap_ch, cap_close, cap_dat;
  logic [STAGES:0]                  vld_pipe;
  logic [1:0]                       shift_en;
  logic [1:0][DATA_WIDTH-1:0]       word_nxt;
  logic [DATA_WIDTH-1:0]            left_lat, right_lat;
  logic                             have_left;

  assign bclk_rise = sync2[2] & ~bclk_d;
  assign lr_now    = sync2[1];
  assign dat_now   = sync2[0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1  <= '0;
      sync2  <= '0;
      bclk_d <= 1'b0;
    end else begin
      sync1  <= {i_bclk, i_lrclk, i_afAdcData};
      sync2  <= sync1;
      bclk_d <= sync2[2];
    end
  end

  // Bits are only captured once an LRCLK edge has been seen, so the first half-word is never partial
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lr_init     <= 1'b0;
      lr_valid    <= 1'b0;
      lr_prev     <= 1'b0;
      cap_ch      <= 1'b0;
      cap_close   <= 1'b0;
      cap_dat     <= 1'b0;
      vld_pipe[0] <= 1'b0;
    end else begin
      vld_pipe[0] <= 1'b0;
      if (bclk_rise) begin
        lr_init <= 1'b1;
        lr_prev <= lr_now;
        if (lr_init) begin
          if (lr_now != lr_prev) lr_valid <= 1'b1;
          vld_pipe[0] <= lr_valid;
          cap_ch      <= lr_prev;
          cap_close   <= (lr_now != lr_prev);
          cap_dat     <= dat_now;
        end
      end
    end
  end

  always_comb begin
    shift_en = 2'b00;
    if (vld_pipe[0]) shift_en = cap_ch ? 2'b10 : 2'b01;
  end

`ifdef ADAU1361_RX_FRAME_CHECK_EN
  logic [1:0] len_err;
`endif

  for (genvar c = 0; c < 2; c++) begin : g_ch
    adau1361_rx_chan #(.W(DATA_WIDTH)) u_ch (
      .clk      (i_clk),
      .rst      (i_reset),
      .shift    (shift_en[c]),
      .dat      (cap_dat),
`ifdef ADAU1361_RX_FRAME_CHECK_EN
      .close    (cap_close),
      .len_err  (len_err[c]),
`endif
      .word_nxt (word_nxt[c])
    );
  end

  // A right word only completes a frame if its left partner was captured first
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      left_lat    <= '0;
      right_lat   <= '0;
      have_left   <= 1'b0;
      vld_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1] <= 1'b0;
      if (vld_pipe[0] && cap_close) begin
        if (!cap_ch) begin
          left_lat  <= word_nxt[0];
          have_left <= 1'b1;
        end else if (have_left) begin
          right_lat   <= word_nxt[1];
          have_left   <= 1'b0;
          vld_pipe[1] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid     <= 1'b0;
      o_leftData  <= '0;
      o_rightData <= '0;
      o_overrun   <= 1'b0;
    end else begin
      if (vld_pipe[1]) begin
        if (!o_valid || i_ready) begin
          o_valid     <= 1'b1;
          o_leftData  <= left_lat;
          o_rightData <= right_lat;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef ADAU1361_RX_FRAME_CHECK_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                         o_frameError <= 1'b0;
    else if (vld_pipe[0] && cap_close && len_err[cap_ch]) o_frameError <= 1'b1;
  end
`else
  assign o_frameError = 1'b0;
`endif

endmodule

// File: tb/tb_adau1361_receiver.sv
// Directed bench for adau1361_receiver: I2S frames driven from i_clk-aligned tasks, delivered pairs logged by a monitor.

module tb_adau1361_receiver;

  localparam int DW   = 16;
  localparam int HALF = 32;
`ifdef ADAU1361_RX_FRAME_CHECK_EN
  localparam logic FE_EXP = 1'b1;
`else
  localparam logic FE_EXP = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_bclk = 1'b0;
  logic          i_lrclk = 1'b0;
  logic          i_afAdcData = 1'b0;
  logic          i_ready = 1'b0;
  logic          o_valid, o_overrun, o_frameError;
  logic [DW-1:0] o_leftData, o_rightData;

  int            n_run = 0;
  int            n_fail = 0;
  logic          pend = 1'b0;
  bit            probe = 1'b0;
  int            lat = -1;
  int            base = 0;
  logic [DW-1:0] rx_l[$];
  logic [DW-1:0] rx_r[$];
  int            run_len = 0;
  int            max_run = 0;

  always #5 i_clk = ~i_clk;

  adau1361_receiver #(.DATA_WIDTH(DW)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_bclk       (i_bclk),
    .i_lrclk      (i_lrclk),
    .i_afAdcData  (i_afAdcData),
    .i_ready      (i_ready),
    .o_valid      (o_valid),
    .o_leftData   (o_leftData),
    .o_rightData  (o_rightData),
    .o_overrun    (o_overrun),
    .o_frameError (o_frameError)
  );

  always @(negedge i_clk) begin
    if (i_reset) begin
      run_len <= 0;
      max_run <= 0;
    end else begin
      run_len <= o_valid ? run_len + 1 : 0;
      if (o_valid && (run_len + 1 > max_run)) max_run <= run_len + 1;
      if (o_valid && i_ready) begin
        rx_l.push_back(o_leftData);
        rx_r.push_back(o_rightData);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One BCLK period: data/LRCLK change on the falling edge; optional probe times o_valid after the rise
  task automatic bclk_cycle(input logic lr, input logic d);
    @(posedge i_clk); #1;
    i_bclk = 1'b0; i_lrclk = lr; i_afAdcData = d;
    repeat (HALF) @(posedge i_clk);
    #1 i_bclk = 1'b1;
    for (int k = 1; k < HALF; k++) begin
      @(posedge i_clk); #1;
      if (probe && o_valid) begin
        lat   = k - 1;
        probe = 1'b0;
      end
    end
  endtask

  // I2S one-BCLK delay: first slot of a half carries the previous word's LSB
  task automatic send_half(input logic lr, input logic [DW-1:0] w, input int nb);
    for (int i = 0; i < nb; i++) begin
      if (i == 0) bclk_cycle(lr, pend);
      else        bclk_cycle(lr, w[DW-i]);
    end
    pend = w[DW-nb];
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int rbits);
    send_half(1'b0, l, DW);
    send_half(1'b1, r, rbits);
  endtask

  task automatic do_reset(input string tag);
    @(posedge i_clk); #1 i_reset = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk({tag, "_rst_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_rst_left"}, 32'(o_leftData), 32'd0);
    chk({tag, "_rst_right"}, 32'(o_rightData), 32'd0);
    chk({tag, "_rst_ovr"}, 32'(o_overrun), 32'd0);
    chk({tag, "_rst_ferr"}, 32'(o_frameError), 32'd0);
    @(posedge i_clk); #1 i_reset = 1'b0;
  endtask

  initial begin
    // Basic streaming with a ready consumer plus latency measurement
    do_reset("a");
    i_ready = 1'b1;
    base = rx_l.size();
    send_frame(16'h8001, 16'h7FFE, DW);
    send_frame(16'h8001, 16'h7FFE, DW);
    probe = 1'b1; lat = -1;
    send_frame(16'h8001, 16'h7FFE, DW);
    probe = 1'b0;
    send_frame(16'h8001, 16'h7FFE, DW);
    send_half(1'b0, 16'h0000, DW);
    chk("b_count", 32'(rx_l.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (base + i < rx_l.size()) begin
        chk("b_left", 32'(rx_l[base+i]), 32'h8001);
        chk("b_right", 32'(rx_r[base+i]), 32'h7FFE);
      end
    end
    chk("b_pulse", 32'(max_run), 32'd1);
    chk("b_latency", 32'(lat), 32'd4);
    chk("b_ovr", 32'(o_overrun), 32'd0);
    chk("b_ferr", 32'(o_frameError), 32'd0);

    // Stalled consumer: first pair held, later frames dropped
    i_ready = 1'b0;
    do_reset("c");
    send_frame(16'hDEAD, 16'hBEEF, DW);
    send_frame(16'h1111, 16'h2222, DW);
    send_frame(16'h3333, 16'h4444, DW);
    send_frame(16'h5555, 16'h6666, DW);
    send_half(1'b0, 16'h0000, DW);
    @(negedge i_clk);
    chk("c_valid", 32'(o_valid), 32'd1);
    chk("c_left", 32'(o_leftData), 32'h1111);
    chk("c_right", 32'(o_rightData), 32'h2222);
    chk("c_ovr", 32'(o_overrun), 32'd1);
    base = rx_l.size();
    @(posedge i_clk); #1 i_ready = 1'b1;
    @(posedge i_clk); #1 i_ready = 1'b0;
    @(negedge i_clk);
    chk("c_drop", 32'(o_valid), 32'd0);
    chk("c_ovr_sticky", 32'(o_overrun), 32'd1);
    chk("c_acc_cnt", 32'(rx_l.size() - base), 32'd1);
    if (rx_l.size() > base) chk("c_acc_left", 32'(rx_l[base]), 32'h1111);

    // Handshake lands in the same cycle as a frame completion
    do_reset("d");
    send_frame(16'hDEAD, 16'hBEEF, DW);
    send_frame(16'h0A0A, 16'h0B0B, DW);
    send_frame(16'h0C0C, 16'h0D0D, DW);
    @(negedge i_clk);
    chk("d_hold_valid", 32'(o_valid), 32'd1);
    chk("d_hold_left", 32'(o_leftData), 32'h0A0A);
    base = rx_l.size();
    @(posedge i_clk); #1;
    i_bclk = 1'b0; i_lrclk = 1'b0; i_afAdcData = pend;
    repeat (HALF) @(posedge i_clk);
    #1 i_bclk = 1'b1;
    repeat (4) @(posedge i_clk);
    #1 i_ready = 1'b1;
    @(posedge i_clk); #1 i_ready = 1'b0;
    @(negedge i_clk);
    chk("d_valid", 32'(o_valid), 32'd1);
    chk("d_left", 32'(o_leftData), 32'h0C0C);
    chk("d_right", 32'(o_rightData), 32'h0D0D);
    chk("d_ovr", 32'(o_overrun), 32'd0);
    chk("d_acc_cnt", 32'(rx_l.size() - base), 32'd1);
    if (rx_l.size() > base) chk("d_acc_right", 32'(rx_r[base]), 32'h0B0B);
    repeat (HALF) @(posedge i_clk);

    // Short right half-frame
    do_reset("e");
    i_ready = 1'b1;
    base = rx_l.size();
    send_frame(16'hDEAD, 16'hBEEF, DW);
    send_frame(16'h1234, 16'h5678, DW);
    send_half(1'b0, 16'h4321, DW);
    chk("e_ferr_clean", 32'(o_frameError), 32'd0);
    send_half(1'b1, 16'h8765, DW - 1);
    send_frame(16'h1111, 16'h2222, DW);
    send_half(1'b0, 16'h0000, DW);
    chk("e_ferr", 32'(o_frameError), 32'(FE_EXP));
    chk("e_count", 32'(rx_l.size() - base), 32'd3);
    if (rx_l.size() > base + 1) begin
      chk("e_short_left", 32'(rx_l[base+1]), 32'h4321);
      chk("e_short_right", 32'(rx_r[base+1]), 32'h43B2);
    end

    // Reset in the middle of a left word
    do_reset("f");
    send_frame(16'hDEAD, 16'hBEEF, DW);
    send_frame(16'h1234, 16'h5678, DW);
    send_half(1'b0, 16'hABCD, 8);
    @(negedge i_clk);
    chk("f_pre_left", 32'(o_leftData), 32'h1234);
    do_reset("f2");
    base = rx_l.size();
    send_frame(16'h0F0F, 16'hF0F0, DW);
    send_frame(16'h1357, 16'h2468, DW);
    send_half(1'b0, 16'h0000, DW);
    chk("f_count", 32'(rx_l.size() - base), 32'd1);
    if (rx_l.size() > base) begin
      chk("f_left", 32'(rx_l[base]), 32'h1357);
      chk("f_right", 32'(rx_r[base]), 32'h2468);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/adau1361_receiver.md
ADAU1361_RECEIVER -- requirements
Module: adau1361_receiver

Interface
REQ-001 Parameter DATA_WIDTH, default 16: bits per channel word and BCLK periods per LRCLK half-period.
REQ-002 i_clk  input  1  system clock; all logic on its rising edge; frequency SHALL be at least 4x BCLK.
REQ-003 i_reset  input  1  asynchronous, active-high reset.
REQ-004 i_bclk  input  1  codec bit clock, asynchronous to i_clk.
REQ-005 i_lrclk  input  1  codec frame clock, asynchronous; low = left channel, high = right channel.
REQ-006 i_afAdcData  input  1  codec ADC serial data, MSB first, I2S format.
REQ-007 i_ready  input  1  consumer accepts the held sample pair.
REQ-008 o_valid  output  1  sample pair held on o_leftData/o_rightData.
REQ-009 o_leftData  output  DATA_WIDTH  left word, two's complement, as received.
REQ-010 o_rightData  output  DATA_WIDTH  right word.
REQ-011 o_overrun  output  1  sticky: a completed frame was dropped.
REQ-012 o_frameError  output  1  sticky: half-frame bit count mismatch (macro-dependent, REQ-031).

Function
REQ-013 i_bclk, i_lrclk, i_afAdcData SHALL each pass through a 2-flop synchroniser; a BCLK rise is the i_clk cycle where synchronised BCLK is 1 and its previous value 0.
REQ-014 On each BCLK rise the block SHALL sample synchronised LRCLK (lr_now) and data, and retain lr_prev from the previous rise.
REQ-015 Each data bit SHALL be attributed to channel lr_prev and shifted MSB-first into that channel's shift register.
REQ-016 A rise with lr_now != lr_prev SHALL mark the current bit as the LSB of channel lr_prev (1-BCLK I2S delay) and close that word.
REQ-017 Closing a left word (lr_prev=0) SHALL latch it internally and set a have-left flag.
REQ-018 Closing a right word (lr_prev=1) with have-left set SHALL complete a frame; have-left is then cleared.
REQ-019 A closed right word without have-left (partial first frame after reset) SHALL be discarded silently.
REQ-020 Frame completion with o_valid=0, or o_valid=1 and i_ready=1 in the same cycle, SHALL load outputs and assert o_valid on the next i_clk edge.
REQ-021 Frame completion with o_valid=1 and i_ready=0 SHALL drop the new frame, keep held data unchanged, and set o_overrun.
REQ-022 o_valid SHALL stay high with stable data until sampled with i_ready=1, then deassert next cycle unless REQ-020 reloads.
REQ-023 Latency: o_valid SHALL rise exactly 4 i_clk edges after the first edge at which raw i_bclk is sampled high on the frame-closing rise.
REQ-024 Bit counter per half-frame SHALL saturate at 63; shift registers keep the last DATA_WIDTH bits received.
REQ-025 No bits SHALL be captured before the first LRCLK transition after reset (lr_prev invalid until then).

Reset
REQ-026 While i_reset=1: o_valid=0, o_leftData=0, o_rightData=0, o_overrun=0, o_frameError=0, synchronisers, shift registers, counters, have-left and lr_prev-valid flag cleared.
REQ-027 Reset asserted mid-frame SHALL abandon the partial frame; after release capture resumes per REQ-025.
REQ-028 Sticky flags SHALL clear only by reset.

Configuration
REQ-029 Macro ADAU1361_RX_FRAME_CHECK_EN selects half-frame length checking.
REQ-030 Defined: any closed word whose bit count != DATA_WIDTH SHALL set o_frameError; that frame SHALL still be delivered if otherwise complete.
REQ-031 Undefined: no checking logic; o_frameError SHALL be tied to 0.

Verification
REQ-032 Reset, i_clk 100 MHz, BCLK 1.536 MHz, left 0x8001, right 0x7FFE, i_ready=1 -> after first discarded partial frame, o_valid 1-cycle pulse with 0x8001/0x7FFE each frame.
REQ-033 i_ready=0 for 3 frames (0x1111/0x2222, 0x3333/0x4444, 0x5555/0x6666) -> held 0x1111/0x2222, o_overrun=1; i_ready=1 -> valid drops next cycle.
REQ-034 Frame closes in same cycle as i_ready=1 handshake -> new pair loaded, o_valid stays high, o_overrun stays 0.
REQ-035 Macro defined, one right half-frame with 15 BCLKs -> o_frameError=1; macro undefined same stimulus -> o_frameError=0.
REQ-036 i_reset pulsed after 8 left bits of 0xABCD -> outputs 0 during reset; next delivered pair is first fully captured frame, no 0xAB remnants.
REQ-037 Measure o_valid rise vs frame-closing BCLK edge -> exactly 4 i_clk edges per REQ-023.
